// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: op encodings, FSM states
// and the size/store/sign decode helpers used by the stage and its lane aligner.
package mem_stage_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LD   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_LHU  = 4'd6,
    MEM_LWU  = 4'd7,
    MEM_SB   = 4'd8,
    MEM_SH   = 4'd9,
    MEM_SW   = 4'd10,
    MEM_SD   = 4'd11
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // Codes 12..15 are unused and behave like MEM_NONE.
  function automatic logic op_is_mem(input logic [OP_W-1:0] op);
    return (op >= MEM_LB) && (op <= MEM_SD);
  endfunction

  function automatic logic op_is_store(input logic [OP_W-1:0] op);
    return (op >= MEM_SB) && (op <= MEM_SD);
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
  endfunction

  // log2 of the access size in bytes.
  function automatic logic [1:0] op_size_log2(input logic [OP_W-1:0] op);
    logic [1:0] sl;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: sl = SIZE_B;
      MEM_LH, MEM_LHU, MEM_SH: sl = SIZE_H;
      MEM_LW, MEM_LWU, MEM_SW: sl = SIZE_W;
      default:                 sl = SIZE_D;
    endcase
    return sl;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store mask/data placement, load
// extraction with sign/zero extension, and misalignment detection.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata,
  output logic            misalign
);

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [1:0]      sl,
                                             input logic            sgn);
    logic [XLEN-1:0] r;
    case (sl)
      SIZE_B:  r = {{(XLEN-8){sgn & d[7]}}, d[7:0]};
      SIZE_H:  r = {{(XLEN-16){sgn & d[15]}}, d[15:0]};
      SIZE_W:  r = {{(XLEN-32){sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  logic [1:0]      size_log2;
  logic [7:0]      lane_bits;
  logic [2:0]      align_mask;
  logic [5:0]      bit_shift;
  logic [XLEN-1:0] rdata_shifted;

  always_comb begin
    size_log2 = op_size_log2(op);
    case (size_log2)
      SIZE_B:  begin lane_bits = 8'h01; align_mask = 3'b000; end
      SIZE_H:  begin lane_bits = 8'h03; align_mask = 3'b001; end
      SIZE_W:  begin lane_bits = 8'h0F; align_mask = 3'b011; end
      default: begin lane_bits = 8'hFF; align_mask = 3'b111; end
    endcase
    bit_shift     = {off, 3'b000};
    misalign      = op_is_mem(op) && ((off & align_mask) != 3'b000);
    wmask         = op_is_store(op) ? (lane_bits << off) : 8'h00;
    wdata         = store_data << bit_shift;
    rdata_shifted = rdata >> bit_shift;
    ldata         = extend(rdata_shifted, size_log2, op_is_signed(op));
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding req/ack data port plus a
// valid/ready write-back record for the register-file stage.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_res,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [OP_W-1:0]   in_mem_op,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_rd_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_rd_wen,
  output logic [XLEN-1:0]   out_rd_data,
  output logic              out_misalign,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wmask,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata
);

  state_e            state;
  logic [OP_W-1:0]   op_p1;
  logic [2:0]        off_p1;
  logic [REG_AW-1:0] rd_addr_p1;
  logic              rd_wen_p1;

  logic [OP_W-1:0]   la_op;
  logic [2:0]        la_off;
  logic [7:0]        la_wmask;
  logic [XLEN-1:0]   la_wdata;
  logic [XLEN-1:0]   la_ldata;
  logic              la_misalign;

  logic              accept;
  logic              wen_p0;

  // HOLD accepts like IDLE: the pending record retires in the same cycle
  // out_ready is seen, so the slot is free for the next operation.
  assign in_ready = (state != ST_REQ) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign wen_p0   = in_rd_wen && (in_rd_addr != '0) && !op_is_store(in_mem_op);

  // One aligner serves both phases: incoming op at accept, held op at ack.
  assign la_op  = (state == ST_REQ) ? op_p1  : in_mem_op;
  assign la_off = (state == ST_REQ) ? off_p1 : in_alu_res[2:0];

  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .op         (la_op),
    .off        (la_off),
    .store_data (in_store_data),
    .rdata      (dmem_rdata),
    .wmask      (la_wmask),
    .wdata      (la_wdata),
    .ldata      (la_ldata),
    .misalign   (la_misalign)
  );

  // p0 -> p1: operation context held for the duration of the access
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1      <= in_mem_op;
      off_p1     <= in_alu_res[2:0];
      rd_addr_p1 <= in_rd_addr;
      rd_wen_p1  <= wen_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      out_valid    <= 1'b0;
      out_rd_addr  <= '0;
      out_rd_wen   <= 1'b0;
      out_rd_data  <= '0;
      out_misalign <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_wmask   <= 8'h00;
    end else begin
      case (state)
        ST_REQ: begin
          if (dmem_ack) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_wmask   <= 8'h00;
            out_valid    <= 1'b1;
            out_rd_addr  <= rd_addr_p1;
            out_misalign <= 1'b0;
            out_rd_wen   <= op_is_store(op_p1) ? 1'b0 : rd_wen_p1;
            out_rd_data  <= op_is_store(op_p1) ? '0 : la_ldata;
            state        <= ST_HOLD;
          end
        end
        default: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
          if (accept) begin
            if (!op_is_mem(in_mem_op)) begin
              out_valid    <= 1'b1;
              out_rd_addr  <= in_rd_addr;
              out_rd_wen   <= wen_p0;
              out_rd_data  <= in_alu_res;
              out_misalign <= 1'b0;
            end else if (la_misalign) begin
              out_valid    <= 1'b1;
              out_rd_addr  <= in_rd_addr;
              out_rd_wen   <= 1'b0;
              out_rd_data  <= in_alu_res;
              out_misalign <= 1'b1;
            end else begin
              state      <= ST_REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= op_is_store(in_mem_op);
              dmem_addr  <= {in_alu_res[XLEN-1:3], 3'b000};
              dmem_wdata <= la_wdata;
              dmem_wmask <= la_wmask;
            end
          end
        end
      endcase
    end
  end

endmodule
